// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter.
//   NUM_MASTERS : number of requesters sharing the RAM
//   RD / WR     : encoding of the request type on mN_we
//   mem_req_t   : one requester's command bundle at the default widths
package ram_port_arbiter_pkg;

  localparam int NUM_MASTERS = 2;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  localparam int AWIDTH_DEF = 7;
  localparam int DWIDTH_DEF = 16;

  typedef struct packed {
    logic                  we;
    logic [AWIDTH_DEF-1:0] addr;
    logic [DWIDTH_DEF-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/ram_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
//   req  : request vector, bit N = requester N
//   prio : favoured requester when both request
//   gnt  : one-hot grant (or all zero when nobody requests)
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = prio ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbiter sharing one simple-dual-port block RAM between two requesters.
// A write and a read from different requesters proceed together, one on
// each RAM port; two requests of the same type are resolved round-robin.
//   clk, rst        : clock, synchronous active-high reset
//   mN_req/we/addr/wdata : requester N command, held until mN_gnt
//   mN_gnt          : combinational accept
//   mN_rvalid/rdata : read return, one cycle after the read grant
//   ram_*           : RAM write port, read port and registered read data
//   conflict_cnt    : saturating count of same-type collision cycles
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 7,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [AWIDTH-1:0] m0_addr,
  input  logic [DWIDTH-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DWIDTH-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [AWIDTH-1:0] m1_addr,
  input  logic [DWIDTH-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DWIDTH-1:0] m1_rdata,
  output logic [DWIDTH-1:0] ram_di,
  output logic              ram_wren,
  output logic [AWIDTH-1:0] ram_wraddr,
  output logic              ram_rden,
  output logic [AWIDTH-1:0] ram_rdaddr,
  input  logic [DWIDTH-1:0] ram_do,
  output logic [CWIDTH-1:0] conflict_cnt
);

  typedef struct packed {
    logic              we;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdata;
  } req_t;

  function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] v);
    return (&v) ? v : v + CWIDTH'(1);
  endfunction

  req_t                   mreq [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] rd_req;
  logic [NUM_MASTERS-1:0] wr_req;
  logic [NUM_MASTERS-1:0] gnt_rd;
  logic [NUM_MASTERS-1:0] gnt_wr;
  logic                   conflict;
  logic                   prio;
  logic                   rd_pend;
  logic                   rd_owner;

  assign mreq[0] = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
  assign mreq[1] = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};
  assign req     = {m1_req, m0_req};

  always_comb begin
    rd_req = '0;
    wr_req = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      rd_req[i] = req[i] && (mreq[i].we == RD);
      wr_req[i] = req[i] && (mreq[i].we == WR);
    end
  end

  // Reads and writes never compete with each other, so each port has its
  // own picker; both share the one prio bit.
  rr_pick2 u_pick_rd (.req(rd_req), .prio(prio), .gnt(gnt_rd));
  rr_pick2 u_pick_wr (.req(wr_req), .prio(prio), .gnt(gnt_wr));

  assign conflict = !rst && ((&rd_req) || (&wr_req));
  assign m0_gnt   = !rst && (gnt_rd[0] || gnt_wr[0]);
  assign m1_gnt   = !rst && (gnt_rd[1] || gnt_wr[1]);

  always_comb begin
    ram_wren   = 1'b0;
    ram_wraddr = '0;
    ram_di     = '0;
    ram_rden   = 1'b0;
    ram_rdaddr = '0;
    if (!rst) begin
      if (|gnt_wr) begin
        ram_wren   = 1'b1;
        ram_wraddr = mreq[gnt_wr[1]].addr;
        ram_di     = mreq[gnt_wr[1]].wdata;
      end
      if (|gnt_rd) begin
        ram_rden   = 1'b1;
        ram_rdaddr = mreq[gnt_rd[1]].addr;
      end
    end
  end

  // Grant stage -> read-return stage
  always_ff @(posedge clk) begin
    if (rst) begin
      prio         <= 1'b0;
      rd_pend      <= 1'b0;
      rd_owner     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      // The picker granted index prio, so the loser is ~prio.
      if (conflict) begin
        prio         <= ~prio;
        conflict_cnt <= sat_inc(conflict_cnt);
      end
      rd_pend <= |gnt_rd;
      if (|gnt_rd) begin
        rd_owner <= gnt_rd[1];
      end
    end
  end

  // A reset in the return cycle drops the pending response.
  assign m0_rvalid = !rst && rd_pend && (rd_owner == 1'b0);
  assign m1_rvalid = !rst && rd_pend && (rd_owner == 1'b1);
  assign m0_rdata  = ram_do;
  assign m1_rdata  = ram_do;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  localparam int DW = 16;
  localparam int AW = 7;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [DW-1:0] ram_di;
  logic          ram_wren, ram_rden;
  logic [AW-1:0] ram_wraddr, ram_rdaddr;
  logic [DW-1:0] ram_do = '0;
  logic [CW-1:0] conflict_cnt;

  ram_port_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_di(ram_di), .ram_wren(ram_wren), .ram_wraddr(ram_wraddr),
    .ram_rden(ram_rden), .ram_rdaddr(ram_rdaddr), .ram_do(ram_do),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Simple-dual-port RAM, registered read, read-first.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (ram_rden) ram_do <= mem[ram_rdaddr];
    if (ram_wren) mem[ram_wraddr] <= ram_di;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model state
  logic          fav;
  int            cnt;
  logic [DW-1:0] ref_mem [2**AW];

  typedef struct {
    logic          owner;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t sbq[$];
  rsp_t mon_r;

  // One clock cycle: drive inputs, check combinational outputs against the
  // model, queue any expected read response.
  task automatic cycle(input logic rs,
                       input logic q0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic q1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       output logic [1:0] g);
    logic          rq [2];
    logic          we [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    logic          ewren, erden, confl, rown;
    logic [AW-1:0] ewa, era;
    logic [DW-1:0] edi;
    @(negedge clk);
    rst = rs;
    m0_req = q0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = q1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    if (rs) sbq.delete();
    #2;
    rq[0] = q0; rq[1] = q1; we[0] = w0; we[1] = w1;
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    g = 2'b00; ewren = 0; erden = 0; ewa = '0; era = '0; edi = '0; rown = 0;
    confl = !rs && rq[0] && rq[1] && (we[0] == we[1]);
    if (!rs) begin
      if (confl) begin
        g[fav] = 1'b1;
        fav = ~fav;
      end else begin
        g = {rq[1], rq[0]};
      end
      for (int i = 0; i < 2; i++) begin
        if (g[i] && we[i]) begin
          ewren = 1; ewa = a[i]; edi = d[i];
        end else if (g[i]) begin
          erden = 1; era = a[i]; rown = 1'(i);
        end
      end
    end
    chk("m0_gnt", 32'(m0_gnt), 32'(g[0]));
    chk("m1_gnt", 32'(m1_gnt), 32'(g[1]));
    chk("ram_wren", 32'(ram_wren), 32'(ewren));
    chk("ram_wraddr", 32'(ram_wraddr), 32'(ewa));
    chk("ram_di", 32'(ram_di), 32'(edi));
    chk("ram_rden", 32'(ram_rden), 32'(erden));
    chk("ram_rdaddr", 32'(ram_rdaddr), 32'(era));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(cnt));
    if (erden) sbq.push_back('{rown, ref_mem[era]});
    if (ewren) ref_mem[ewa] = edi;
    if (confl && cnt < CMAX) cnt++;
    if (rs) begin
      fav = 1'b0;
      cnt = 0;
    end
  endtask

  // Read-return monitor
  always @(negedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      mon_r = sbq.pop_front();
      chk("m0_rvalid", 32'(m0_rvalid), 32'(!mon_r.owner));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(mon_r.owner));
      chk("rdata", 32'(mon_r.owner ? m1_rdata : m0_rdata), 32'(mon_r.data));
    end else begin
      chk("m0_rvalid_idle", 32'(m0_rvalid), 32'd0);
      chk("m1_rvalid_idle", 32'(m1_rvalid), 32'd0);
    end
  end

  logic [1:0]    gg;
  logic          h_rq [2];
  logic          h_we [2];
  logic [AW-1:0] h_a [2];
  logic [DW-1:0] h_d [2];

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    fav = 1'b0;
    cnt = 0;

    cycle(1, 0,0,0,0, 0,0,0,0, gg);
    cycle(1, 0,0,0,0, 0,0,0,0, gg);
    // write then read back
    cycle(0, 1,1,7'd5,16'h1234, 0,0,0,0, gg);
    cycle(0, 0,0,0,0, 1,0,7'd5,0, gg);
    cycle(0, 0,0,0,0, 0,0,0,0, gg);
    // read conflict held two cycles
    cycle(0, 1,0,7'd1,0, 1,0,7'd2,0, gg);
    cycle(0, 1,0,7'd1,0, 1,0,7'd2,0, gg);
    chk("cnt_after_two_conflicts", 32'(cnt), 32'd2);
    // same-address read and write: old data, then new
    cycle(0, 1,1,7'd9,16'hBEEF, 1,0,7'd9,0, gg);
    cycle(0, 0,0,0,0, 1,0,7'd9,0, gg);
    cycle(0, 0,0,0,0, 0,0,0,0, gg);
    // saturating write conflicts from reset
    cycle(1, 0,0,0,0, 0,0,0,0, gg);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1,1,7'(k),16'(k+16'h100), 1,1,7'(k+8),16'(k+16'h200), gg);
      chk("sat_alt_grant", 32'(gg), (k % 2 == 0) ? 32'd1 : 32'd2);
    end
    cycle(0, 0,0,0,0, 0,0,0,0, gg);
    // read dropped by reset in its return cycle
    cycle(0, 1,0,7'd9,0, 0,0,0,0, gg);
    cycle(1, 0,0,0,0, 0,0,0,0, gg);
    cycle(0, 0,0,0,0, 0,0,0,0, gg);

    for (int i = 0; i < 2; i++) begin
      h_rq[i] = 0; h_we[i] = 0; h_a[i] = '0; h_d[i] = '0;
    end
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!h_rq[i] || gg[i]) begin
          h_rq[i] = ($urandom % 4) != 0;
          h_we[i] = 1'($urandom % 2);
          h_a[i]  = 7'($urandom % 8);
          h_d[i]  = 16'($urandom);
        end
      end
      cycle(($urandom % 50) == 0, h_rq[0], h_we[0], h_a[0], h_d[0],
            h_rq[1], h_we[1], h_a[1], h_d[1], gg);
    end
    cycle(0, 0,0,0,0, 0,0,0,0, gg);
    cycle(0, 0,0,0,0, 0,0,0,0, gg);
    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
